display_scan_mux: RTL
=====================

// Module: display_scan_mux
// PURPOSE
//  Time-multiplexes the four registered 7-segment patterns (seg0..seg3, active-low, 0 = lit)
//  onto one shared segment bus with per-digit active-low anode selects for the chess-clock display.
//  Sits downstream of the digit-to-segment decoder and drives the board display pins directly.
//  A blanking gap between digits prevents ghosting.
// PARAMETERS
//  TICKS_PER_DIGIT  50000  CE-qualified cycles each digit is lit (>=1; 1 ms at 50 MHz)
//  BLANK_TICKS      16     CE-qualified cycles all anodes are off between digits (>=1)
//  CNT_W            16     timer width; must hold max(TICKS_PER_DIGIT,BLANK_TICKS)-1
// PORTS
//  CLK         in   1  system clock, all logic on rising edge
//  CLR_N       in   1  reset, synchronous, active-low
//  CE          in   1  clock enable; timers and state advance only when 1
//  seg0..seg3  in   7  active-low segment patterns for digits 0 (rightmost) .. 3 (leftmost)
//  seg_n       out  7  shared segment bus, active-low, registered
//  an_n        out  4  anode selects, active-low, one-hot-low or all-high, registered
//  frame_tick  out  1  one-cycle pulse on the edge digit 0 becomes lit
// BEHAVIOUR
//  - Reset (CLR_N=0 at edge): state=BLANK, idx=0, timer=0, seg_n=7'h7F, an_n=4'b1111, frame_tick=0, snapshot=7'h7F.
//    Reset overrides CE and takes effect on any edge, including mid-SHOW.
//  - FSM states BLANK, SHOW. Outputs registered from next-state: they change on the same edge as state.
//  - BLANK: seg_n=7'h7F, an_n=4'b1111. Timer increments per CE cycle; on the CE cycle with
//    timer==BLANK_TICKS-1 -> SHOW, timer=0, snapshot=seg[idx], an_n=~(4'b0001<<idx), seg_n=seg[idx].
//  - SHOW: an_n/seg_n hold the snapshot; live seg inputs ignored until next visit (no tearing).
//    On CE cycle with timer==TICKS_PER_DIGIT-1 -> BLANK, timer=0, idx=idx+1 mod 4 (3 wraps to 0).
//  - Each digit: exactly BLANK_TICKS blank then TICKS_PER_DIGIT lit CE cycles;
//    frame = 4*(BLANK_TICKS+TICKS_PER_DIGIT) CE cycles.
//  - CE=0: timer, idx, state, outputs frozen; frame_tick forced 0 in that cycle.
//  - frame_tick=1 for exactly one clock on the BLANK->SHOW edge with idx==0; else 0.
//  - Never more than one anode low; an_n and seg_n always change on the same edge.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: at BLANK->SHOW of idx 3, if seg3==SEG_ZERO_N, slot stays dark
//    (an_n=4'b1111, seg_n=7'h7F) with unchanged timing. For idx 2, dark if seg2==SEG_ZERO_N
//    and digit 3 was dark in this frame. Digits 1,0 always lit. frame_tick unaffected.
//  Not defined: all four digits always lit; zero-detect logic absent.
// STRUCTURE
//  - Package display_pkg: SEG_BLANK_N=7'h7F, SEG_ZERO_N=7'b1000000, state encoding
//    (BLANK=1'b0, SHOW=1'b1), DIGITS=4. Shared with the segment decoder.
//  - Sub-module scan_timer: CE-gated up-counter, CNT_W wide, sync clear, terminal-count
//    compare against a runtime limit input (BLANK_TICKS-1 or TICKS_PER_DIGIT-1).
//  - Top: FSM, idx register, snapshot register, output registers.
// TESTING  (TICKS_PER_DIGIT=4, BLANK_TICKS=2, CE=1 unless stated)
//  1. CLR_N=0 one edge from any state -> seg_n=7'h7F, an_n=4'b1111, frame_tick=0 next cycle.
//  2. seg0=7'h40,seg1=7'h79,seg2=7'h24,seg3=7'h30, release reset -> 2 cyc dark, 4 cyc
//     an_n=1110/seg_n=40, 2 dark, 1101/79, 2 dark, 1011/24, 2 dark, 0111/30; repeats every
//     24 cycles; frame_tick on cycles 2, 26, 50.
//  3. Change seg1 7'h79->7'h12 on 2nd lit cycle of digit 1 -> seg_n stays 79 for that slot,
//     shows 12 on next frame's digit-1 slot.
//  4. CE=0 for 10 cycles during 2nd lit cycle of digit 2 -> outputs frozen, digit 2 lit for
//     exactly 4 CE cycles total, no frame_tick while CE=0.
//  5. CLR_N=0 during digit-3 SHOW -> all off next edge; after release, 2 dark then digit 0.
//  6. seg3=seg2=seg1=7'h40, seg0=7'h79: with LEADING_ZERO_BLANK_EN slots 3,2 stay 4'b1111,
//     slot 1 lit 1101/40; without macro all four lit, frame period still 24.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: constants shared by the segment decoder and the display scan mux.
//   SEG_BLANK_N  all segments off (active-low)
//   SEG_ZERO_N   active-low pattern of the digit '0'
//   DIGITS       number of multiplexed digits
//   scan_state_t scan FSM encoding (BLANK=0, SHOW=1)
//   anode_sel_n  active-low one-hot anode select for a digit index
package display_pkg;

  localparam logic [6:0] SEG_BLANK_N = 7'h7F;
  localparam logic [6:0] SEG_ZERO_N  = 7'b1000000;
  localparam int         DIGITS      = 4;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  function automatic logic [3:0] anode_sel_n(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/display_scan_mux_timer.sv
// scan_timer: clock-enable gated up-counter with synchronous clear and a
// terminal-count compare against a runtime limit.
// Ports:
//   clk    in   system clock (rising edge)
//   clr_n  in   synchronous active-low reset, count -> 0
//   ce     in   clock enable; count and clear act only when 1
//   clr    in   synchronous clear (qualified by ce)
//   limit  in   terminal value; tc is high while count == limit
//   count  out  current count
//   tc     out  terminal-count flag (combinational from count/limit)
module scan_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ce,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count_reg <= '0;
    end else if (ce) begin
      if (clr) begin
        count_reg <= '0;
      end else begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign count = count_reg;
  assign tc    = (count_reg == limit);

endmodule

// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexes four active-low 7-segment patterns onto a
// shared segment bus with active-low anode selects, inserting an all-dark gap
// between digits to avoid ghosting. Each digit's pattern is snapshotted when
// its slot starts, so live input changes never tear a lit digit.
// Ports:
//   CLK         in   system clock (rising edge)
//   CLR_N       in   synchronous active-low reset (overrides CE)
//   CE          in   clock enable; timer, index, state and outputs advance only when 1
//   seg0..seg3  in   active-low patterns, digit 0 rightmost .. digit 3 leftmost
//   seg_n       out  shared segment bus, active-low, registered
//   an_n        out  anode selects, active-low, at most one low, registered
//   frame_tick  out  one-clock pulse on the edge digit 0 becomes lit
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, a '0' on digit 3 keeps that slot dark, and a '0' on digit 2
//   keeps its slot dark when the latest digit-3 slot was dark. Timing and
//   frame_tick are unchanged. When undefined all four digits are always lit.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 50000,
  parameter int BLANK_TICKS     = 16,
  parameter int CNT_W           = 16
) (
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic       CE,
  input  logic [6:0] seg0,
  input  logic [6:0] seg1,
  input  logic [6:0] seg2,
  input  logic [6:0] seg3,
  output logic [6:0] seg_n,
  output logic [3:0] an_n,
  output logic       frame_tick
);

  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_TICKS - 1);
  localparam logic [CNT_W-1:0] SHOW_LIM  = CNT_W'(TICKS_PER_DIGIT - 1);

  scan_state_t      state_reg, state_next;
  logic [1:0]       idx_reg, idx_next;
  logic [6:0]       snap_reg, snap_next;
  logic [6:0]       seg_reg, seg_next;
  logic [3:0]       an_reg, an_next;
  logic             tick_reg, tick_next;
  logic [CNT_W-1:0] timer_count;
  logic [CNT_W-1:0] timer_limit;
  logic             timer_tc;
  logic             advance;
  logic [6:0]       live_seg;
  logic             slot_dark;
  logic [6:0]       seg_arr [DIGITS];

  assign seg_arr[0] = seg0;
  assign seg_arr[1] = seg1;
  assign seg_arr[2] = seg2;
  assign seg_arr[3] = seg3;

  assign timer_limit = (state_reg == SHOW) ? SHOW_LIM : BLANK_LIM;
  // A phase ends only on a CE-qualified cycle at terminal count.
  assign advance     = CE && timer_tc;
  assign live_seg    = seg_arr[idx_reg];

  scan_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (CLK),
    .clr_n (CLR_N),
    .ce    (CE),
    .clr   (timer_tc),
    .limit (timer_limit),
    .count (timer_count),
    .tc    (timer_tc)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Remembers whether the most recent digit-3 slot was suppressed.
  logic dark3_reg, dark3_next;

  always_comb begin
    slot_dark  = 1'b0;
    dark3_next = dark3_reg;
    if (advance && state_reg == BLANK) begin
      if (idx_reg == 2'd3) begin
        slot_dark  = (live_seg == SEG_ZERO_N);
        dark3_next = slot_dark;
      end else if (idx_reg == 2'd2) begin
        slot_dark  = (live_seg == SEG_ZERO_N) && dark3_reg;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      dark3_reg <= 1'b0;
    end else begin
      dark3_reg <= dark3_next;
    end
  end
`else
  assign slot_dark = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      state_reg <= BLANK;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    if (advance) begin
      state_next = (state_reg == BLANK) ? SHOW : BLANK;
    end
  end

  // Output / datapath next values; outputs are registered from these so they
  // change on the same edge as the state.
  always_comb begin
    idx_next  = idx_reg;
    snap_next = snap_reg;
    seg_next  = snap_reg;
    an_next   = an_reg;
    tick_next = 1'b0;
    if (state_reg == BLANK) begin
      seg_next = SEG_BLANK_N;
    end
    if (advance) begin
      if (state_reg == BLANK) begin
        snap_next = live_seg;
        tick_next = (idx_reg == 2'd0);
        if (slot_dark) begin
          seg_next = SEG_BLANK_N;
          an_next  = 4'b1111;
        end else begin
          seg_next = live_seg;
          an_next  = anode_sel_n(idx_reg);
        end
      end else begin
        idx_next = idx_reg + 2'd1;
        seg_next = SEG_BLANK_N;
        an_next  = 4'b1111;
      end
    end else if (state_reg == SHOW && an_reg == 4'b1111) begin
      // Suppressed slot stays dark for its whole duration.
      seg_next = SEG_BLANK_N;
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      idx_reg  <= 2'd0;
      snap_reg <= SEG_BLANK_N;
      seg_reg  <= SEG_BLANK_N;
      an_reg   <= 4'b1111;
      tick_reg <= 1'b0;
    end else begin
      idx_reg  <= idx_next;
      snap_reg <= snap_next;
      seg_reg  <= seg_next;
      an_reg   <= an_next;
      tick_reg <= tick_next;
    end
  end

  assign seg_n      = seg_reg;
  assign an_n       = an_reg;
  assign frame_tick = tick_reg;

endmodule
